// File: rtl/pic_pkg.sv
// Shared definitions for the pic_claim interrupt controller: register offsets,
// per-line state encoding, default decode window and a constant clog2.
package pic_pkg;

  localparam logic [31:0] DefAddrBase = 32'h0000_2000;
  localparam logic [31:0] DefAddrMask = 32'hFFFF_FF00;

  // prio[i] lives at 4*i for every offset below OffEnable
  localparam logic [31:0] OffEnable    = 32'h80;
  localparam logic [31:0] OffThreshold = 32'h84;
  localparam logic [31:0] OffPending   = 32'h88;
  localparam logic [31:0] OffActive    = 32'h8C;
  localparam logic [31:0] OffMode      = 32'h90;

  typedef enum logic [1:0] {
    LineIdle    = 2'd0,
    LinePending = 2'd1,
    LineActive  = 2'd2
  } line_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pic_select_tree.sv
// Registered winner selection: balanced pairwise max tree over {eligible, prio, ~index},
// so the highest priority wins and ties fall to the lowest index.
module pic_select_tree #(
  parameter int unsigned LINES  = 32,
  parameter int unsigned PRIO_W = 3,
  parameter int unsigned CODE_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LINES-1:0]             eligible,
  input  logic [LINES-1:0][PRIO_W-1:0] prio,
  input  logic                         clear,
  output logic                         exi,
  output logic [CODE_W-1:0]            exi_code
);

  localparam int unsigned Leaves = 1 << CODE_W;
  localparam int unsigned KeyW   = 1 + PRIO_W + CODE_W;

  // Heap layout: node[1] is the root, leaves sit at Leaves..2*Leaves-1.
  logic [2*Leaves-1:1][KeyW-1:0] node;
  logic [KeyW-1:0]               root;

  always_comb begin
    node = '0;
    for (int j = 0; j < LINES; j++) begin
      node[Leaves + j] = {eligible[j], prio[j], ~CODE_W'(j)};
    end
    for (int n = Leaves - 1; n >= 1; n--) begin
      node[n] = (node[2*n] >= node[2*n+1]) ? node[2*n] : node[2*n+1];
    end
  end

  assign root = node[1];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      exi      <= 1'b0;
      exi_code <= '0;
    end else begin
      exi      <= root[KeyW-1];
      exi_code <= root[KeyW-1] ? ~root[CODE_W-1:0] : '0;
    end
  end

endmodule

// File: rtl/pic_claim.sv
// Priority interrupt controller with per-line IDLE/PENDING/ACTIVE claim/complete tracking.
// Define PIC_EDGE_EN to add per-line edge-triggered mode (mode bitmap at offset 0x90).
module pic_claim
  import pic_pkg::*;
#(
  parameter int unsigned LINES     = 32,
  parameter int unsigned PRIO_W    = 3,
  parameter logic [31:0] ADDR_BASE = DefAddrBase,
  parameter logic [31:0] ADDR_MASK = DefAddrMask,
  parameter int unsigned CODE_W    = clog2(LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINES-1:0]  irq,
  output logic              exi,
  output logic [CODE_W-1:0] exi_code,
  input  logic              exi_claim,
  input  logic              exi_done,
  input  logic [CODE_W-1:0] exi_done_code,
  input  logic              mgmt_req,
  input  logic [31:0]       mgmt_adr,
  input  logic              mgmt_rwn,
  input  logic [31:0]       mgmt_txd,
  output logic              mgmt_ack,
  output logic [31:0]       mgmt_rxd
);

  logic [LINES-1:0]             irq_q, en_q, pend_map, act_map, eligible;
  logic [LINES-1:0]             set_req, drop_req, repend, claim_hit, done_hit;
  logic [LINES-1:0][PRIO_W-1:0] prio_q;
  logic [PRIO_W-1:0]            thr_q;
  line_state_e                  state_q [LINES];
  logic [31:0]                  off, rd_data;
  logic [4:0]                   prio_idx;
  logic                         hit, wr_en, prio_sel, claim_en;

  assign hit      = mgmt_req && ((mgmt_adr & ADDR_MASK) == ADDR_BASE);
  assign off      = mgmt_adr & ~ADDR_MASK;
  assign wr_en    = hit && !mgmt_rwn;
  assign prio_sel = (off < OffEnable) && (off[1:0] == 2'b00);
  assign prio_idx = off[6:2];
  // A claim only counts while an interrupt is actually being presented.
  assign claim_en = exi_claim && exi;

  always_comb begin
    for (int i = 0; i < LINES; i++) begin
      pend_map[i]  = (state_q[i] == LinePending);
      act_map[i]   = (state_q[i] == LineActive);
      eligible[i]  = pend_map[i] && (prio_q[i] > thr_q);
      claim_hit[i] = claim_en && (exi_code == CODE_W'(i));
      done_hit[i]  = exi_done && (exi_done_code == CODE_W'(i));
    end
  end

`ifdef PIC_EDGE_EN
  logic [LINES-1:0] mode_q, irq_prev_q, repend_q, rise;

  assign rise     = irq_q & ~irq_prev_q;
  assign set_req  = (mode_q & rise) | (~mode_q & irq_q);
  assign drop_req = ~mode_q & ~irq_q;
  assign repend   = repend_q | (mode_q & rise);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= '0;
      irq_prev_q <= '0;
      repend_q   <= '0;
    end else begin
      irq_prev_q <= irq_q;
      if (wr_en && off == OffMode) mode_q <= mgmt_txd[LINES-1:0];
      for (int i = 0; i < LINES; i++) begin
        if (act_map[i] && done_hit[i]) repend_q[i] <= 1'b0;
        else if (act_map[i] && mode_q[i] && rise[i]) repend_q[i] <= 1'b1;
      end
    end
  end
`else
  assign set_req  = irq_q;
  assign drop_req = ~irq_q;
  assign repend   = '0;
`endif

  always_comb begin
    rd_data = '0;
    if (prio_sel) begin
      for (int i = 0; i < LINES; i++) begin
        if (prio_idx == 5'(i)) rd_data[PRIO_W-1:0] = prio_q[i];
      end
    end else begin
      case (off)
        OffEnable:    rd_data[LINES-1:0]  = en_q;
        OffThreshold: rd_data[PRIO_W-1:0] = thr_q;
        OffPending:   rd_data[LINES-1:0]  = pend_map;
        OffActive:    rd_data[LINES-1:0]  = act_map;
`ifdef PIC_EDGE_EN
        OffMode:      rd_data[LINES-1:0]  = mode_q;
`endif
        default:      rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q    <= '0;
      en_q     <= '0;
      prio_q   <= '0;
      thr_q    <= '0;
      mgmt_ack <= 1'b0;
      mgmt_rxd <= '0;
    end else begin
      irq_q    <= irq;
      mgmt_ack <= hit;
      mgmt_rxd <= (hit && mgmt_rwn) ? rd_data : '0;
      if (wr_en) begin
        if (prio_sel) begin
          for (int i = 0; i < LINES; i++) begin
            if (prio_idx == 5'(i)) prio_q[i] <= mgmt_txd[PRIO_W-1:0];
          end
        end
        if (off == OffEnable)    en_q  <= mgmt_txd[LINES-1:0];
        if (off == OffThreshold) thr_q <= mgmt_txd[PRIO_W-1:0];
      end
    end
  end

  // Per-line FSM; done is handled in the ACTIVE arm, claim in the PENDING arm, so both
  // can land in the same cycle on different lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) state_q[i] <= LineIdle;
    end else begin
      for (int i = 0; i < LINES; i++) begin
        case (state_q[i])
          LineIdle: begin
            if (en_q[i] && set_req[i]) state_q[i] <= LinePending;
          end
          LinePending: begin
            if (claim_hit[i]) state_q[i] <= LineActive;
            else if (!en_q[i] || drop_req[i]) state_q[i] <= LineIdle;
          end
          LineActive: begin
            if (done_hit[i]) state_q[i] <= repend[i] ? LinePending : LineIdle;
          end
          default: state_q[i] <= LineIdle;
        endcase
      end
    end
  end

  pic_select_tree #(
    .LINES (LINES),
    .PRIO_W(PRIO_W),
    .CODE_W(CODE_W)
  ) u_select (
    .clk     (clk),
    .rst     (rst),
    .eligible(eligible),
    .prio    (prio_q),
    .clear   (claim_en),
    .exi     (exi),
    .exi_code(exi_code)
  );

endmodule

// File: tb/tb_pic_claim.sv
// Self-checking bench for pic_claim: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the line states, selection and register map.
module tb_pic_claim;

  localparam logic [31:0] A    = 32'h0000_2000;
  localparam logic [31:0] MASK = 32'hFFFF_FF00;

  logic        clk, rst;
  logic [31:0] irq;
  logic        exi, exi_claim, exi_done;
  logic [4:0]  exi_code, exi_done_code;
  logic        mgmt_req, mgmt_rwn, mgmt_ack;
  logic [31:0] mgmt_adr, mgmt_txd, mgmt_rxd;

  int total = 0;
  int bad   = 0;

  // model state: 0 idle, 1 pending, 2 active
  int          m_state [32];
  logic [2:0]  m_prio [32];
  logic [31:0] m_irq_q, m_prev, m_en, m_mode, m_rep, m_rxd;
  logic [2:0]  m_thr;
  logic        m_exi, m_ack;
  logic [4:0]  m_code;

  pic_claim dut (
    .clk          (clk),
    .rst          (rst),
    .irq          (irq),
    .exi          (exi),
    .exi_code     (exi_code),
    .exi_claim    (exi_claim),
    .exi_done     (exi_done),
    .exi_done_code(exi_done_code),
    .mgmt_req     (mgmt_req),
    .mgmt_adr     (mgmt_adr),
    .mgmt_rwn     (mgmt_rwn),
    .mgmt_txd     (mgmt_txd),
    .mgmt_ack     (mgmt_ack),
    .mgmt_rxd     (mgmt_rxd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] off);
    logic [31:0] pend, act;
    pend = '0;
    act  = '0;
    for (int i = 0; i < 32; i++) begin
      pend[i] = (m_state[i] == 1);
      act[i]  = (m_state[i] == 2);
    end
    if (off < 32'h80 && off[1:0] == 2'b00) return {29'd0, m_prio[off[6:2]]};
    case (off)
      32'h80:  return m_en;
      32'h84:  return {29'd0, m_thr};
      32'h88:  return pend;
      32'h8C:  return act;
`ifdef PIC_EDGE_EN
      32'h90:  return m_mode;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int          best;
    int          ns [32];
    logic        claim_ok, hit;
    logic [31:0] off, rdv, rise;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_state[i] = 0;
        m_prio[i]  = '0;
      end
      m_irq_q = '0; m_prev = '0; m_en = '0; m_mode = '0; m_rep = '0; m_thr = '0;
      m_exi = 1'b0; m_code = '0; m_ack = 1'b0; m_rxd = '0;
      return;
    end
    best = -1;
    for (int i = 0; i < 32; i++) begin
      if (m_state[i] == 1 && m_prio[i] > m_thr && (best < 0 || m_prio[i] > m_prio[best]))
        best = i;
    end
    claim_ok = exi_claim && m_exi;
    hit      = mgmt_req && ((mgmt_adr & MASK) == A);
    off      = mgmt_adr & ~MASK;
    rdv      = m_read(off);
    rise     = m_irq_q & ~m_prev;
    for (int i = 0; i < 32; i++) begin
      ns[i] = m_state[i];
      if (m_state[i] == 0) begin
        if (m_en[i] && (m_mode[i] ? rise[i] : m_irq_q[i])) ns[i] = 1;
      end else if (m_state[i] == 1) begin
        if (claim_ok && m_code == 5'(i)) ns[i] = 2;
        else if (!m_en[i] || (!m_mode[i] && !m_irq_q[i])) ns[i] = 0;
      end else begin
        if (exi_done && exi_done_code == 5'(i)) begin
          ns[i]    = (m_rep[i] || (m_mode[i] && rise[i])) ? 1 : 0;
          m_rep[i] = 1'b0;
        end else if (m_mode[i] && rise[i]) begin
          m_rep[i] = 1'b1;
        end
      end
    end
    if (hit && !mgmt_rwn) begin
      if (off < 32'h80 && off[1:0] == 2'b00) m_prio[off[6:2]] = mgmt_txd[2:0];
      else if (off == 32'h80) m_en = mgmt_txd;
      else if (off == 32'h84) m_thr = mgmt_txd[2:0];
`ifdef PIC_EDGE_EN
      else if (off == 32'h90) m_mode = mgmt_txd;
`endif
    end
    m_ack  = hit;
    m_rxd  = (hit && mgmt_rwn) ? rdv : 32'd0;
    m_exi  = (best >= 0) && !claim_ok;
    m_code = (best >= 0 && !claim_ok) ? best[4:0] : 5'd0;
    for (int i = 0; i < 32; i++) m_state[i] = ns[i];
    m_prev  = m_irq_q;
    m_irq_q = irq;
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    chk("exi", {31'd0, exi}, {31'd0, m_exi});
    chk("exi_code", {27'd0, exi_code}, {27'd0, m_code});
    chk("mgmt_ack", {31'd0, mgmt_ack}, {31'd0, m_ack});
    chk("mgmt_rxd", mgmt_rxd, m_rxd);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus(input logic rwn, input logic [31:0] adr, input logic [31:0] data);
    mgmt_req = 1'b1; mgmt_rwn = rwn; mgmt_adr = adr; mgmt_txd = data;
    tick();
    mgmt_req = 1'b0;
  endtask

  task automatic pulse_claim();
    exi_claim = 1'b1; tick(); exi_claim = 1'b0;
  endtask

  task automatic pulse_done(input logic [4:0] code);
    exi_done = 1'b1; exi_done_code = code; tick(); exi_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  initial begin
    int          k;
    logic [31:0] a;
    rst = 1'b1; irq = '0; exi_claim = 1'b0; exi_done = 1'b0; exi_done_code = '0;
    mgmt_req = 1'b0; mgmt_adr = '0; mgmt_rwn = 1'b0; mgmt_txd = '0;
    #2;
    tick();
    chk("reset_exi", {31'd0, exi}, 32'd0);
    chk("reset_rxd", mgmt_rxd, 32'd0);
    rst = 1'b0;
    tick();

    // equal priorities: lowest index first, next winner one cycle after the claim
    bus(1'b0, A + 32'h0C, 32'd5);
    bus(1'b0, A + 32'h1C, 32'd5);
    bus(1'b0, A + 32'h80, 32'h88);
    irq = 32'h88;
    ticks(3);
    chk("tie_exi", {31'd0, exi}, 32'd1);
    chk("tie_code", {27'd0, exi_code}, 32'd3);
    pulse_claim();
    chk("claim_clears_exi", {31'd0, exi}, 32'd0);
    tick();
    chk("next_winner_exi", {31'd0, exi}, 32'd1);
    chk("next_winner_code", {27'd0, exi_code}, 32'd7);

    // threshold blocks equal priority, lowering it releases the line
    do_reset();
    bus(1'b0, A + 32'h84, 32'd4);
    bus(1'b0, A + 32'h08, 32'd4);
    bus(1'b0, A + 32'h80, 32'h4);
    irq = 32'h4;
    ticks(4);
    chk("thr_block", {31'd0, exi}, 32'd0);
    bus(1'b0, A + 32'h84, 32'd3);
    tick();
    chk("thr_release_exi", {31'd0, exi}, 32'd1);
    chk("thr_release_code", {27'd0, exi_code}, 32'd2);

    // claim, ignored done, then completion with irq still high re-pends
    do_reset();
    bus(1'b0, A + 32'h14, 32'd2);
    bus(1'b0, A + 32'h80, 32'h20);
    irq = 32'h20;
    ticks(3);
    chk("l5_code", {27'd0, exi_code}, 32'd5);
    pulse_claim();
    pulse_done(5'd9);
    bus(1'b1, A + 32'h8C, 32'd0);
    chk("active_map", mgmt_rxd, 32'h20);
    chk("active_ack", {31'd0, mgmt_ack}, 32'd1);
    bus(1'b1, A + 32'h88, 32'd0);
    chk("pending_map", mgmt_rxd, 32'h0);
    pulse_done(5'd5);
    chk("done_exi0", {31'd0, exi}, 32'd0);
    tick();
    chk("done_exi1", {31'd0, exi}, 32'd0);
    tick();
    chk("repend_exi", {31'd0, exi}, 32'd1);
    chk("repend_code", {27'd0, exi_code}, 32'd5);

    // register readback and decode miss
    bus(1'b0, A + 32'h00, 32'd6);
    bus(1'b1, A + 32'h00, 32'd0);
    chk("prio0_ack", {31'd0, mgmt_ack}, 32'd1);
    chk("prio0_rxd", mgmt_rxd, 32'd6);
    tick();
    chk("ack_single", {31'd0, mgmt_ack}, 32'd0);
    bus(1'b1, A + 32'h100, 32'd0);
    chk("miss_ack", {31'd0, mgmt_ack}, 32'd0);
    chk("miss_rxd", mgmt_rxd, 32'd0);

    // reset while one line is active and another is being presented
    bus(1'b0, A + 32'h18, 32'd1);
    bus(1'b0, A + 32'h80, 32'h60);
    irq = 32'h60;
    ticks(3);
    pulse_claim();
    tick();
    chk("pre_rst_code", {27'd0, exi_code}, 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_exi", {31'd0, exi}, 32'd0);
    bus(1'b1, A + 32'h8C, 32'd0);
    chk("rst_active", mgmt_rxd, 32'd0);
    bus(1'b1, A + 32'h88, 32'd0);
    chk("rst_pending", mgmt_rxd, 32'd0);
    bus(1'b1, A + 32'h90, 32'd0);
    chk("mode_read", mgmt_rxd, 32'd0);

`ifdef PIC_EDGE_EN
    // edge line latches a one-cycle pulse and re-pends after a pulse while active
    irq = '0;
    do_reset();
    bus(1'b0, A + 32'h90, 32'h2);
    bus(1'b0, A + 32'h04, 32'd3);
    bus(1'b0, A + 32'h80, 32'h2);
    irq = 32'h2; tick(); irq = '0;
    ticks(3);
    chk("edge_code", {27'd0, exi_code}, 32'd1);
    chk("edge_exi", {31'd0, exi}, 32'd1);
    pulse_claim();
    irq = 32'h2; tick(); irq = '0;
    ticks(2);
    pulse_done(5'd1);
    tick();
    chk("edge_repend", {31'd0, exi}, 32'd1);
`endif

    // random traffic
    irq = $urandom;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 32; b++) if ($urandom_range(15) == 0) irq[b] = ~irq[b];
      exi_claim     = ($urandom_range(3) == 0);
      exi_done      = ($urandom_range(3) == 0);
      exi_done_code = 5'($urandom_range(31));
      if ($urandom_range(2) != 0) begin
        for (int i = 0; i < 32; i++)
          if (m_state[i] == 2 && $urandom_range(1) == 0) exi_done_code = 5'(i);
      end
      mgmt_req = ($urandom_range(2) == 0);
      mgmt_rwn = $urandom_range(1) == 1;
      mgmt_txd = $urandom;
      k = $urandom_range(9);
      case (k)
        0, 1, 2, 3: a = 32'(4 * $urandom_range(31));
        4:          a = 32'h80;
        5: begin
          a = 32'h84;
          mgmt_txd = 32'($urandom_range(3));
        end
        6:          a = 32'h88;
        7:          a = 32'h8C;
        8:          a = 32'h90 + 32'(4 * $urandom_range(27));
        default:    a = $urandom_range(1) ? 32'h100 + 32'($urandom_range(255))
                                          : 32'($urandom_range(255)) | 32'h1;
      endcase
      mgmt_adr = A + a;
      rst = ($urandom_range(999) == 0);
      tick();
    end
    rst = 1'b0; mgmt_req = 1'b0; exi_claim = 1'b0; exi_done = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
